// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Purpose  : Shared types and default sizing for the multiplier arbiter.
//            Holds the sequencer state encoding, the default requester
//            count, operand width and timeout, and the derived id width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mult_arb_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 32;
  localparam int DEF_ID_W    = $clog2(DEF_N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    RUN   = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

endpackage : mult_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Scans the request vector
//            starting at index ptr and wrapping, and grants the first
//            requester found.
// Ports    : req       - request vector, one bit per requester
//            ptr       - index where the search starts
//            grant     - one-hot grant (all zero when nothing requests)
//            grant_idx - binary index of the granted requester
//            any       - at least one request present
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW-1:0] w_cand;

  // The first hit in circular order from ptr wins; later hits are ignored
  // because any is already set.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IDW'((int'(ptr) + k) % N);
      if (!any && req[w_cand]) begin
        any            = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Purpose  : Shares one iterative multiplier between N requesters. Grants
//            one requester at a time in round-robin order, starts the
//            multiplier, follows its ready level through busy and done,
//            and returns the product tagged with the requester id. A hung
//            multiplier is abandoned after TIMEOUT cycles with an error
//            response.
// Ports    : clk_in, rst_in      - clock, synchronous active-high reset
//            req_valid/x/y       - per-requester operand offers
//            req_ready           - one-hot accept pulse (IDLE only)
//            rsp_valid/id/       - one-cycle tagged response
//            rsp_product/rsp_err
//            mul_start/x/y       - multiplier command side
//            mul_product/ready   - multiplier result side
// Revision : 1.0  initial release
// ============================================================================
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N-1:0]                req_valid,
  input  logic [N-1:0][WIDTH-1:0]     req_x,
  input  logic [N-1:0][WIDTH-1:0]     req_y,
  output logic [N-1:0]                req_ready,
  output logic                        rsp_valid,
  output logic [$clog2(N)-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]          rsp_product,
  output logic                        rsp_err,
  output logic                        mul_start,
  output logic [WIDTH-1:0]            mul_x,
  output logic [WIDTH-1:0]            mul_y,
  input  logic [2*WIDTH-1:0]          mul_product,
  input  logic                        mul_ready
);

  localparam int             IDW  = $clog2(N);
  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [IDW-1:0] LAST = IDW'(N - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;

  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic [2*WIDTH-1:0] r_prod;
  logic              r_err;
  logic [CW-1:0]     r_cnt;
  logic              r_hold;

  logic [N-1:0]      w_grant;
  logic [IDW-1:0]    w_grant_idx;
  logic              w_any;
  logic              w_take;
  logic              w_capture;
  logic              w_expire;
  logic              w_timeout;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_take    = (r_state == IDLE) && w_any && !r_hold;
  assign mul_x     = r_x;
  assign mul_y     = r_y;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_product = '0;
    rsp_err     = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        // r_hold keeps the first cycle after reset free of grants.
        if (w_any && !r_hold) begin
          req_ready = w_grant;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        w_next    = BUSY;
      end
      BUSY: begin
        // Ready still high here is the previous result; wait for the drop.
        // Nothing can be captured yet, so an expiry takes precedence.
        if (w_timeout) begin
          w_expire = 1'b1;
          w_next   = RESP;
        end else if (!mul_ready) begin
          w_next = RUN;
        end
      end
      RUN: begin
        // A genuine result arriving on the last allowed cycle is kept.
        if (mul_ready) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else if (w_timeout) begin
          w_expire = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_id      = r_id;
        rsp_product = r_prod;
        rsp_err     = r_err;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold <= 1'b1;
      r_ptr  <= '0;
      r_id   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_prod <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_hold <= 1'b0;
      if (w_take) begin
        r_id  <= w_grant_idx;
        r_x   <= req_x[w_grant_idx];
        r_y   <= req_y[w_grant_idx];
        r_ptr <= (w_grant_idx == LAST) ? '0 : w_grant_idx + IDW'(1);
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == BUSY) || (r_state == RUN)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_prod <= mul_product;
        r_err  <= 1'b0;
      end
      if (w_expire) begin
        r_prod <= '0;
        r_err  <= 1'b1;
      end
    end
  end

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Purpose  : Self-checking bench for mult_arbiter. A behavioural multiplier
//            with programmable stale-ready, latency and hang behaviour sits
//            on the multiplier side; a transaction-level reference predicts
//            grants, start pulses and tagged responses cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 32;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_x;
  logic [N-1:0][W-1:0]   req_y;
  logic [N-1:0]          req_ready;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [2*W-1:0]        rsp_product;
  logic                  rsp_err;
  logic                  mul_start;
  logic [W-1:0]          mul_x;
  logic [W-1:0]          mul_y;
  logic [2*W-1:0]        mul_product;
  logic                  mul_ready;

  mult_arbiter #(
    .N       (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_start   (mul_start),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_product (mul_product),
    .mul_ready   (mul_ready)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: one outstanding transaction at most.
  bit busy = 0, hold = 0, zero_ops = 1;
  int ptr = 0, g_cyc = 0, rsp_cyc = 0, exp_id = 0, exp_x = 0, exp_y = 0;
  bit exp_err = 0;
  int n_grants = 0;

  // Parameters for the next granted operation, and for the one in flight.
  int nS = 0, nL = 4, nmode = 0;   // mode 0 normal, 1 hang low, 2 hang high
  int oS = 0, oL = 4, omode = 0;

  // Behavioural multiplier state.
  bit m_act = 0;
  int m_s = 0, m_x = 0, m_y = 0, mS = 0, mL = 0, mmode = 0;

  // Stimulus controls.
  bit           rst_drv = 1;
  int           pol = 1;           // 0 random, 1 fixed table
  logic [N-1:0] fix_valid = '0;
  int           fix_x[N];
  int           fix_y[N];
  bit           drop_on_grant = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    int d, prod;
    rst_in = rst_drv;
    if (pol == 0) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_x[i] = W'($urandom);
        req_y[i] = W'($urandom);
      end
    end else begin
      req_valid = fix_valid;
      for (int i = 0; i < N; i++) begin
        req_x[i] = W'(fix_x[i]);
        req_y[i] = W'(fix_y[i]);
      end
    end
    mul_ready   = 1'b1;
    mul_product = '0;
    if (m_act) begin
      d    = cyc - m_s;
      prod = m_x * m_y;
      mul_product = 8'(prod ^ 32'h5A);   // deliberately wrong until done
      case (mmode)
        0: begin
          if (d > mS && d <= mS + mL) mul_ready = 1'b0;
          else if (d > mS + mL)       mul_product = 8'(prod);
        end
        1: if (d > mS) mul_ready = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic observe();
    int         w;
    bit         gnt, rsp_now;
    logic [1:0] wi;
    w       = rr_pick(req_valid, ptr);
    gnt     = !busy && !hold && (w >= 0);
    rsp_now = busy && (cyc == rsp_cyc);
    if (!rst_in) begin
      check_eq("req_ready", 32'(req_ready), gnt ? (32'd1 << w) : 32'd0);
      check_eq("mul_start", 32'(mul_start), 32'(busy && (cyc == g_cyc + 1)));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(rsp_now));
      if (rsp_now) begin
        check_eq("rsp_id", 32'(rsp_id), exp_id);
        check_eq("rsp_product", 32'(rsp_product), exp_err ? 0 : exp_x * exp_y);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
      if (!busy) begin
        check_eq("idle_rsp_id", 32'(rsp_id), 0);
        check_eq("idle_rsp_product", 32'(rsp_product), 0);
        check_eq("idle_rsp_err", 32'(rsp_err), 0);
      end
      if (busy && cyc > g_cyc) begin
        check_eq("mul_x", 32'(mul_x), exp_x);
        check_eq("mul_y", 32'(mul_y), exp_y);
      end
      if (zero_ops) begin
        check_eq("mul_x_rst", 32'(mul_x), 0);
        check_eq("mul_y_rst", 32'(mul_y), 0);
      end
    end
    // Advance the reference to the end of this cycle.
    if (rst_in) begin
      busy = 0; ptr = 0; hold = 1; m_act = 0; zero_ops = 1;
    end else begin
      hold = 0;
      if (mul_start) begin
        m_act = 1; m_s = cyc; m_x = int'(mul_x); m_y = int'(mul_y);
        mS = oS; mL = oL; mmode = omode;
      end
      if (rsp_now) busy = 0;
      if (gnt) begin
        wi       = 2'(w);
        busy     = 1;
        g_cyc    = cyc;
        exp_id   = w;
        exp_x    = int'(req_x[wi]);
        exp_y    = int'(req_y[wi]);
        ptr      = (w + 1) % N;
        zero_ops = 0;
        oS = nS; oL = nL; omode = nmode;
        exp_err  = (nmode != 0);
        rsp_cyc  = (nmode == 0) ? cyc + 3 + nS + nL : cyc + TO + 2;
        n_grants++;
        if (drop_on_grant) fix_valid[wi] = 1'b0;
        if (pol == 0) begin
          nS    = $urandom_range(0, 3);
          nL    = $urandom_range(1, 10);
          nmode = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
        end
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk_in);
    observe();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1;
    run(n);
    rst_drv = 0;
  endtask

  task automatic set_op(input int i, input int x, input int y);
    fix_x[i] = x;
    fix_y[i] = y;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin fix_x[i] = 0; fix_y[i] = 0; end
    rst_in = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    mul_ready = 1'b1; mul_product = '0;
    @(posedge clk_in);
    #1;
    do_reset(2);

    // Single request from requester 2, 4-cycle multiplier.
    set_op(2, 11, 13); fix_valid = 4'b0100; drop_on_grant = 1;
    nS = 0; nL = 4; nmode = 0;
    run(12);

    // Fairness: everyone requests continuously from a fresh pointer.
    do_reset(1);
    for (int i = 0; i < N; i++) set_op(i, i + 1, 3);
    fix_valid = 4'b1111; drop_on_grant = 0; nS = 0; nL = 2;
    run(31);
    fix_valid = 4'b0000;
    run(10);

    // Stale ready held for two cycles after start.
    set_op(3, 15, 15); fix_valid = 4'b1000; drop_on_grant = 1;
    nS = 2; nL = 3;
    run(15);

    // Multiplier never drops ready, then a normal operation, then never rises.
    set_op(0, 5, 7); fix_valid = 4'b0001; nmode = 2;
    run(TO + 8);
    set_op(1, 9, 9); fix_valid = 4'b0010; nmode = 0; nS = 1; nL = 3;
    run(12);
    set_op(2, 6, 10); fix_valid = 4'b0100; nmode = 1; nS = 0;
    run(TO + 8);
    nmode = 0;

    // Reset while the multiplier is running.
    set_op(1, 3, 4); fix_valid = 4'b0010; nL = 8;
    run(5);
    do_reset(1);
    for (int i = 0; i < N; i++) set_op(i, 2 * i + 1, i + 2);
    fix_valid = 4'b1111; nL = 2;
    run(40);

    // Requester 1 raises and withdraws while requester 0 is served.
    set_op(0, 7, 8); fix_valid = 4'b0001; nL = 6;
    run(1);
    fix_valid[1] = 1'b1;
    run(2);
    fix_valid[1] = 1'b0;
    run(15);

    // Randomised traffic.
    pol = 0; drop_on_grant = 0;
    nS = 1; nL = 3; nmode = 0;
    run(1500);
    pol = 1; fix_valid = '0;
    run(TO + 8);

    check_eq("grants_seen", 32'(n_grants > 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mult_arbiter
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one iterative `multiplier` between N requesters. It accepts operand pairs, issues `start` to the multiplier, and tracks the multiplier's `ready` through busy and done. It returns each product to its originator, tagged with the requester id, and recovers from a hung multiplier via a timeout. The block sits between client logic and the single `multiplier` instance.

## Interface
- `N`, 4: number of requesters (2..8)
- `WIDTH`, 4: operand width; product is 2*WIDTH
- `TIMEOUT`, 32: max cycles from issue to result before error response
- `clk_in` in 1: clock
- `rst_in` in 1: reset; one clock; reset is synchronous and active-high
- `req_valid` in N: requester i has operands pending
- `req_x` in N×WIDTH: multiplicand per requester
- `req_y` in N×WIDTH: multiplier per requester
- `req_ready` out N: one-hot accept pulse; operands of granted requester captured this edge
- `rsp_valid` out 1: one-cycle response pulse
- `rsp_id` out $clog2(N): requester index of the response
- `rsp_product` out 2*WIDTH: product (0 on error)
- `rsp_err` out 1: response was a timeout
- `mul_start` out 1: start pulse to multiplier
- `mul_x`, `mul_y` out WIDTH: operands to multiplier, stable from issue until response
- `mul_product` in 2*WIDTH: multiplier result
- `mul_ready` in 1: multiplier level flag; high = idle/result valid, low = computing

## Operation
- States: IDLE → ISSUE → BUSY → RUN → RESP → IDLE. Any timeout goes from BUSY or RUN to RESP with error.
- IDLE: if any `req_valid`, the round-robin winner gets `req_ready` high (combinational, this cycle only). The arbiter latches id, x and y, then moves to ISSUE. With no requests it stays in IDLE with all outputs 0.
- Round-robin: search starts at `ptr`. After each grant, `ptr` = winner+1 mod N. Reset `ptr` = 0.
- ISSUE: `mul_start`=1 for exactly one cycle. Clear the timeout counter, then go to BUSY.
- BUSY: wait until `mul_ready`=0 is sampled, then go to RUN. This step discards a stale ready level left over from the previous operation.
- RUN: on sampled `mul_ready`=1, capture `mul_product` and go to RESP.
- Timeout counter increments every cycle in BUSY and RUN. When it reaches TIMEOUT-1, the arbiter goes to RESP with `rsp_err`=1 and product 0.
- RESP: `rsp_valid`=1 for one cycle with `rsp_id`, `rsp_product` and `rsp_err`. Then go to IDLE.
- Exactly one operation is in flight at a time. `req_ready` is never asserted outside IDLE.
- A requester dropping `req_valid` before it is granted loses nothing; it is simply not granted.
- Product is taken from the multiplier unmodified. The arbiter performs no arithmetic.
- Reset mid-operation: the next state is IDLE and the in-flight request is dropped with no response. `mul_start`, `req_ready` and `rsp_valid` are 0 in the cycle after reset is sampled.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `rsp_err`=0, `mul_start`=0, `mul_x`=0, `mul_y`=0, state=IDLE, `ptr`=0.
- Cycle 0: grant (`req_ready`). Cycle 1: `mul_start`. From cycle 2: BUSY.
- If `mul_ready` falls at cycle 2 and rises at cycle k, `rsp_valid` is high at cycle k+1.
- Minimum grant-to-grant spacing is 5 cycles.
- `mul_x` and `mul_y` are registered outputs. They change only on the grant edge.
- A simultaneous request from the requester just served is lower priority than any other pending requester.
- Timeout response: `rsp_valid` at cycle 1+TIMEOUT+1 after the grant, at the latest.

## Structure
- Package `mult_arb_pkg`: state enum `arb_state_t` {IDLE, ISSUE, BUSY, RUN, RESP}, default WIDTH/N/TIMEOUT constants, and the id-width localparam.
- Sub-module `rr_arbiter` (N, `req`, `ptr` → one-hot `grant`, `grant_idx`, `any`): combinational, reusable.
- Top level contains the FSM, the operand/id/product registers, the timeout counter and the `ptr` register.

## Test plan
- Single request: N=4, requester 2 sends x=11, y=13. With a behavioural multiplier of 4-cycle latency, expect `req_ready`=4'b0100 at cycle 0 and `mul_start` at cycle 1. Expect `rsp_valid` with `rsp_id`=2, `rsp_product`=143, `rsp_err`=0 at cycle 7.
- Fairness: all four requesters hold `req_valid` continuously (x=i+1, y=3). Expect grant order 0,1,2,3,0 and products 3,6,9,12 with matching `rsp_id`; no requester is granted twice before all others are granted once.
- Stale ready: the model keeps `mul_ready`=1 for 2 cycles after `start` before dropping. The arbiter must not capture early; the product is correct (x=15, y=15 → 225).
- Timeout: the model never drops `mul_ready` to 0 (or never raises it). Expect `rsp_valid` with `rsp_err`=1, `rsp_product`=0 within TIMEOUT+2 cycles of the grant. The next request then completes normally.
- Reset mid-op: assert `rst_in` during RUN. Expect all outputs 0 the next cycle and no `rsp_valid` for the dropped request. After release, requester 0 is granted first.
- Withdrawn request: requester 1 raises then drops `req_valid` while the arbiter is busy serving 0. Requester 1 receives no grant and no response.
